// File: rtl/rca_word_sequencer.sv
// Wide-word adder that reuses one 8-bit ripple-carry adder, one byte per clock,
// least-significant byte first, with the inter-byte carry held in a register.

module RippleCarryAdder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  output logic [7:0] sum,
  output logic       c_out
);
  logic c;

  always_comb begin
    c   = c_in;
    sum = 8'd0;
    for (int i = 0; i < 8; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    c_out = c;
  end
endmodule

module rca_word_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [8*WORDS-1:0]   in1,
  input  logic [8*WORDS-1:0]   in2,
  input  logic                 c_in,
  output logic                 busy,
  output logic                 done,
  output logic [8*WORDS-1:0]   sum,
  output logic                 c_out,
  output logic                 overflow,
  output logic [1:0]           state_dbg
);
  localparam int W  = 8 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [IW-1:0]   idx_q;
  logic            carry_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    part_q;
  logic [W-1:0]    part_next;
  logic [7:0]      add_sum;
  logic            add_co;
  logic            last;
  logic            accept;

  // Handshake: start is taken on a rising edge whenever busy=0 (IDLE or DONE);
  // done pulses for one cycle when sum/c_out/overflow become valid, and start
  // seen while busy=1 is dropped without touching the latched operands.
  assign accept    = start && (state_q != RUN);
  assign last      = (idx_q == IW'(WORDS - 1));
  assign state_dbg = state_q;

  RippleCarryAdder_8bit u_add (
    .a     (a_q[8*idx_q +: 8]),
    .b     (b_q[8*idx_q +: 8]),
    .c_in  (carry_q),
    .sum   (add_sum),
    .c_out (add_co)
  );

  // The completing cycle must see its own byte, so the result is taken from here.
  always_comb begin
    part_next = part_q;
    part_next[8*idx_q +: 8] = add_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      part_q   <= '0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_q     <= in1;
      b_q     <= in2;
      carry_q <= c_in;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      part_q  <= part_next;
      carry_q <= add_co;
      if (last) begin
        sum      <= part_next;
        c_out    <= add_co;
        overflow <= (a_q[W-1] == b_q[W-1]) && (part_next[W-1] != a_q[W-1]);
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end
endmodule
